// File: rtl/alu_muldiv_seq.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer borrowing the shared ADD/SUB ALU; Done D_WIDTH+1 cycles after Start
// (cycle 1 for divide by zero). No queueing: Start is ignored while Busy, and Kill aborts without a Done pulse.
module alu_muldiv_seq #(
    parameter int D_WIDTH   = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [D_WIDTH-1:0] OpA,
    input  logic [D_WIDTH-1:0] OpB,
    input  logic               Kill,
    output logic               Busy,
    output logic               Done,
    output logic [D_WIDTH-1:0] Result,
    output logic               AluOwn,
    output logic [3:0]         ALUControl,
    output logic [D_WIDTH-1:0] SrcA,
    output logic [D_WIDTH-1:0] SrcB,
    input  logic [D_WIDTH-1:0] ALUResult
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [CNT_WIDTH-1:0] LAST_IT = CNT_WIDTH'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_IT = 2'd1,
        DIV_IT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q;
    logic                 sel_hi_q;
    logic [D_WIDTH-1:0]   opa_q;
    logic [D_WIDTH-1:0]   opb_q;
    logic [D_WIDTH-1:0]   hi_q;
    logic [D_WIDTH-1:0]   lo_q;
    logic [D_WIDTH-1:0]   result_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 own_q;

    logic                 mul_carry;
    logic [D_WIDTH-1:0]   mul_hi_d;
    logic [D_WIDTH-1:0]   mul_lo_d;
    logic                 div_m;
    logic [D_WIDTH-1:0]   div_rs;
    logic                 div_take;
    logic [D_WIDTH-1:0]   div_r_d;
    logic [D_WIDTH-1:0]   div_q_d;
    logic                 last_it;

    // hi_q/lo_q hold {Hi,Lo} for multiply and {R,Q} for divide.
    assign div_m  = hi_q[D_WIDTH-1];
    assign div_rs = {hi_q[D_WIDTH-2:0], lo_q[D_WIDTH-1]};

    always_comb begin
        ALUControl = ALU_ADD;
        SrcA       = '0;
        SrcB       = '0;
        case (state_q)
            MUL_IT: begin
                ALUControl = ALU_ADD;
                SrcA       = hi_q;
                SrcB       = lo_q[0] ? opa_q : '0;
            end
            DIV_IT: begin
                ALUControl = ALU_SUB;
                SrcA       = div_rs;
                SrcB       = opb_q;
            end
            default: begin
                ALUControl = ALU_ADD;
                SrcA       = '0;
                SrcB       = '0;
            end
        endcase
    end

    // The 33rd product bit is recovered from unsigned wrap of the shared adder.
    assign mul_carry = (ALUResult < hi_q);
    assign mul_hi_d  = {mul_carry, ALUResult[D_WIDTH-1:1]};
    assign mul_lo_d  = {ALUResult[0], lo_q[D_WIDTH-1:1]};

    assign div_take  = div_m | (div_rs >= opb_q);
    assign div_r_d   = div_take ? ALUResult : div_rs;
    assign div_q_d   = {lo_q[D_WIDTH-2:0], div_take};

    assign last_it   = (cnt_q == LAST_IT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_hi_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            own_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (Kill) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                own_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (Start) begin
                            sel_hi_q <= Op[0];
                            opa_q    <= OpA;
                            opb_q    <= OpB;
                            cnt_q    <= '0;
                            hi_q     <= '0;
                            busy_q   <= 1'b1;
                            if (Op[1] && (OpB == '0)) begin
                                state_q  <= DONE;
                                own_q    <= 1'b0;
                                done_q   <= 1'b1;
                                result_q <= Op[0] ? OpA : '1;
                            end else if (Op[1]) begin
                                state_q <= DIV_IT;
                                own_q   <= 1'b1;
                                lo_q    <= OpA;
                            end else begin
                                state_q <= MUL_IT;
                                own_q   <= 1'b1;
                                lo_q    <= OpB;
                            end
                        end
                    end
                    MUL_IT: begin
                        hi_q  <= mul_hi_d;
                        lo_q  <= mul_lo_d;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (last_it) begin
                            state_q  <= DONE;
                            own_q    <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= sel_hi_q ? mul_hi_d : mul_lo_d;
                        end
                    end
                    DIV_IT: begin
                        hi_q  <= div_r_d;
                        lo_q  <= div_q_d;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (last_it) begin
                            state_q  <= DONE;
                            own_q    <= 1'b0;
                            done_q   <= 1'b1;
                            result_q <= sel_hi_q ? div_r_d : div_q_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        own_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign AluOwn = own_q;
    assign Result = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: a behavioural ALU closes the loop, results are checked against plain arithmetic.
module tb_alu_muldiv_seq;
    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] OpA;
    logic [W-1:0] OpB;
    logic         Kill;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         AluOwn;
    logic [3:0]   ALUControl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [W-1:0] ALUResult;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_result;

    always #5 clk = ~clk;

    assign ALUResult = (ALUControl == 4'b1000) ? (SrcA - SrcB) : (SrcA + SrcB);

    alu_muldiv_seq #(.D_WIDTH(W), .CNT_WIDTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .Op         (Op),
        .OpA        (OpA),
        .OpB        (OpB),
        .Kill       (Kill),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .AluOwn     (AluOwn),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUResult  (ALUResult)
    );

    function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == '0) ? {W{1'b1}} : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 none, 1 Kill at cycle k, 2 rst at cycle k. Cycle 0 is the Start cycle.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, input int kind, input int k, input string tag);
        bit           dz;
        bit           aborted;
        bit           cut;
        bit           busy_e;
        bit           own_e;
        int           lat;
        int           last_own;
        int           stop;
        int           busy_bad;
        int           own_bad;
        int           alu_bad;
        int           res_bad;
        int           done_cnt;
        int           done_cyc;
        logic [W-1:0] exp_res;
        logic [W-1:0] res_e;
        logic [W-1:0] done_res;

        dz       = op[1] && (b == '0);
        lat      = dz ? 1 : LAT;
        last_own = dz ? 0 : W;
        exp_res  = ref_model(op, a, b);
        aborted  = (kind != 0) && (k < lat);
        stop     = (kind == 1 && k < lat) ? k : ((kind == 2) ? k + 1 : lat + 3);
        busy_bad = 0;
        own_bad  = 0;
        alu_bad  = 0;
        res_bad  = 0;
        done_cnt = 0;
        done_cyc = -1;
        done_res = '0;

        for (int cyc = 0; cyc <= stop; cyc++) begin
            @(posedge clk);
            #1;
            Start = (cyc == 0) || (hold && cyc < lat);
            Kill  = (kind == 1) && (cyc == k);
            rst   = (kind == 2) && (cyc == k);
            if (cyc == 0 || hold) begin
                Op  = op;
                OpA = a;
                OpB = b;
            end else begin
                Op  = 2'($urandom);
                OpA = $urandom;
                OpB = $urandom;
            end
            @(negedge clk);
            cut    = aborted && (cyc > k);
            busy_e = (cyc >= 1) && (cyc <= lat) && !cut;
            own_e  = (cyc >= 1) && (cyc <= last_own) && !cut;
            if (Busy !== busy_e) busy_bad++;
            if (AluOwn !== own_e) own_bad++;
            if (own_e) begin
                if (op[1]) begin
                    if (ALUControl !== 4'b1000 || SrcB !== b) alu_bad++;
                end else begin
                    if (ALUControl !== 4'b0000 || (SrcB !== '0 && SrcB !== a)) alu_bad++;
                end
            end else if (ALUControl !== 4'b0000 || SrcA !== '0 || SrcB !== '0) begin
                alu_bad++;
            end
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                done_res = Result;
            end
            if (!aborted && cyc >= lat) res_e = exp_res;
            else if (kind == 2 && cyc > k) res_e = '0;
            else res_e = last_result;
            if (Result !== res_e) res_bad++;
        end

        check({tag, " busy_seq"}, busy_bad, 0);
        check({tag, " own_seq"}, own_bad, 0);
        check({tag, " alu_drive"}, alu_bad, 0);
        check({tag, " result_hold"}, res_bad, 0);
        if (aborted) begin
            check({tag, " no_done"}, done_cnt, 0);
        end else begin
            check({tag, " done_cycle"}, done_cyc, lat);
            check({tag, " done_count"}, done_cnt, 1);
            check({tag, " result"}, done_res, exp_res);
        end

        if (kind == 2) last_result = '0;
        else if (!aborted) last_result = exp_res;
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        int           r_kind;

        rst         = 1'b1;
        Start       = 1'b0;
        Kill        = 1'b0;
        Op          = 2'd0;
        OpA         = '0;
        OpB         = '0;
        last_result = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset Busy", {31'b0, Busy}, 0);
        check("reset Done", {31'b0, Done}, 0);
        check("reset AluOwn", {31'b0, AluOwn}, 0);
        check("reset Result", Result, 0);
        check("reset ALUControl", {28'b0, ALUControl}, 0);
        check("reset SrcA", SrcA, 0);
        check("reset SrcB", SrcB, 0);

        run_op(2'd0, 32'd7, 32'd6, 1'b0, 0, 0, "mul_7x6");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, "mulhu_max");
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, "mul_max");
        run_op(2'd2, 32'd100, 32'd7, 1'b0, 0, 0, "divu_100_7");
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 0, 0, "remu_100_7");
        run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 0, "divu_mpath");
        run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0, 0, "remu_mpath");
        run_op(2'd2, 32'h1234, 32'd0, 1'b0, 0, 0, "divu_by0");
        run_op(2'd3, 32'h1234, 32'd0, 1'b0, 0, 0, "remu_by0");
        run_op(2'd0, 32'd1234, 32'd5678, 1'b0, 1, 10, "mul_kill10");
        run_op(2'd0, 32'd11, 32'd13, 1'b0, 0, 0, "mul_after_kill");
        run_op(2'd2, 32'd999, 32'd10, 1'b0, 2, 5, "divu_rst5");
        run_op(2'd0, 32'd3, 32'd5, 1'b1, 0, 0, "mul_start_held");
        run_op(2'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1, LAT, "mulhu_kill_done");
        run_op(2'd3, 32'd77, 32'd9, 1'b0, 1, W, "remu_kill_last");
        run_op(2'd0, 32'd2, 32'd2, 1'b0, 1, 0, "kill_over_start");
        run_op(2'd2, 32'h55, 32'd0, 1'b0, 1, 1, "divu_by0_kill_done");

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            if ($urandom_range(0, 7) == 0) r_b = '0;
            else if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(1, 255));
            else r_b = $urandom;
            r_kind = (i % 8 == 7) ? 1 : 0;
            run_op(r_op, r_a, r_b, 1'b0, r_kind, $urandom_range(1, LAT), "rand");
        end

        @(posedge clk);
        #1;
        Start = 1'b0;
        Kill  = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("final idle Busy", {31'b0, Busy}, 0);
        check("final Result", Result, last_result);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
